bcd_lap_timer: RTL
==================

Name: bcd_lap_timer

Overview:
- Parametrised successor to the single-mode 4-digit stopwatch: a BCD time counter in format M..M:SS.F..F.
- Supports up-count (stopwatch) and down-count (countdown from a loaded preset), an expiry flag, and optional lap capture.
- Advances on an external divider strobe and sits between the debounced/one-pulsed button logic and the seven-segment scanner.

Parameters:
- MIN_DIGITS, 1, number of BCD minute digits (1..4); each 0-9.
- FRAC_DIGITS, 1, number of BCD sub-second digits (1..3); each 0-9.
- Derived ND = MIN_DIGITS + 2 + FRAC_DIGITS; W = 4*ND.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous reset, active-low.
- tick  in  1  one-clk strobe per least-significant-digit period (e.g. 1/10 s at FRAC_DIGITS=1).
- start  in  1  one-clk pulse; toggles run/pause.
- clear  in  1  one-clk pulse; return to zero/IDLE.
- load  in  1  one-clk pulse; load preset into time (honoured in IDLE/PAUSE/DONE only).
- load_val  in  W  preset, BCD, same packing as time.
- mode_down  in  1  0 = count up, 1 = count down; sampled only on start from IDLE/PAUSE/DONE.
- time  out  W  current value; nibble [3:0] = least significant fractional digit, then remaining fraction digits, seconds-units, seconds-tens, minutes upward.
- running  out  1  high in RUN.
- expired  out  1  high in DONE.
- lap_time  out  W  captured lap value (LAP_CAPTURE_EN only).
- lap_valid  out  1  lap_time holds a capture (LAP_CAPTURE_EN only).

Behaviour:
- Reset (rst=0, async): state IDLE, time=0, dir=up, running=0, expired=0, lap_time=0, lap_valid=0.
- States: IDLE (zero, stopped), RUN, PAUSE, DONE.
- Control pulses are sampled every clk. Priority: clear > load > start > lap. Only the highest-priority pulse in a cycle acts.
- Transitions:
  - IDLE/PAUSE + start -> RUN. The latched dir takes mode_down at that edge.
  - DONE + start -> RUN only if the time is not at the terminal value for the newly latched dir; otherwise DONE is held.
  - RUN + start -> PAUSE.
  - Any state + clear -> IDLE, time=0, lap_valid=0.
  - load in IDLE/PAUSE/DONE: time<=load_val, state -> PAUSE (-> IDLE if load_val==0), expired cleared. load in RUN is ignored.
- Counting: time changes only on a clk where tick=1 and the registered state is RUN, and no clear or load is acting that cycle.
  - Simultaneous start+tick in RUN: this tick counts, then PAUSE.
  - Simultaneous start+tick in PAUSE: no count, then RUN.
- Up-count:
  - Each fraction digit and seconds-units digit wraps 9->0 with carry.
  - Seconds-tens wraps 5->0 with carry.
  - Minute digits wrap 9->0 with carry.
  - Terminal value = all-max (MIN 9s:59.F 9s, e.g. 9:59.9). The tick that reaches terminal sets DONE and holds time at terminal; there is no wrap to zero.
- Down-count:
  - Each digit borrows: 0->9 (seconds-tens 0->5).
  - The tick that reaches 0 sets DONE with time=0.
  - RUN entered with time already 0 in down mode goes straight to DONE on the next tick, with no count.
- Latency: time, running and expired update on the clk edge of the causing tick or pulse (1 clk, registered outputs).
- load_val digits outside the legal range (>9, or seconds-tens >5) are saturated per digit to 9 (5) on load.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: BCD_LAP_TIMER_LAP_CAPTURE_EN.
- Defined:
  - lap pulse in RUN or PAUSE copies the current time (value before any same-cycle tick update) into lap_time and sets lap_valid=1.
  - lap is ignored in IDLE and DONE.
  - clear and reset zero lap_time and lap_valid.
- Undefined: lap_time and lap_valid are tied to 0; the lap input is unused.

Test Plan:
- Up-count rollover (defaults): load 0:09.9, start up, 1 tick -> time=0:10.0. Load 0:59.9, 1 tick -> 1:00.0.
- Up terminal: load 9:59.8, start up, 3 ticks -> after tick1 9:59.9, expired=1, running=0; tick2/3 leave time at 9:59.9.
- Countdown: load 1:00.0, mode_down=1, start, 1 tick -> 0:59.9. Load 0:00.2, 2 ticks -> 0:00.0, expired=1. Further ticks produce no change.
- Priority/simultaneity: in RUN at 0:05.0, assert start+tick same clk -> time 0:05.1, PAUSE. Then clear+start+load same clk -> IDLE, time 0.
- Async reset mid-RUN: drive rst=0 between clk edges at 3:21.4 -> outputs zero immediately, without waiting for clk. After release, ticks do not count until start.
- Lap (macro defined): RUN at 0:12.3, lap+tick same clk -> lap_time=0:12.3, lap_valid=1, time=0:12.4. Then clear -> lap_valid=0.

Source files
------------

// File: rtl/bcd_lap_timer.sv
// bcd_lap_timer: BCD up/down time counter in M..M:SS.F..F format.
// Counts on an external tick strobe, with an expiry state and preset loading.
// Optional lap capture is enabled by defining BCD_LAP_TIMER_LAP_CAPTURE_EN;
// without it lap_time_o/lap_valid_o are tied low and lap_i is unused.
// Nibble 0 is the least significant fractional digit; nibble FRAC_DIGITS is
// seconds-units, FRAC_DIGITS+1 is seconds-tens, and minutes follow upward.
module bcd_lap_timer #(
  parameter int unsigned MIN_DIGITS  = 1,
  parameter int unsigned FRAC_DIGITS = 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          tick_i,
  input  logic                                          start_i,
  input  logic                                          clear_i,
  input  logic                                          load_i,
  input  logic [4*(MIN_DIGITS+2+FRAC_DIGITS)-1:0]       load_val_i,
  input  logic                                          mode_down_i,
  input  logic                                          lap_i,
  output logic [4*(MIN_DIGITS+2+FRAC_DIGITS)-1:0]       time_o,
  output logic                                          running_o,
  output logic                                          expired_o,
  output logic [4*(MIN_DIGITS+2+FRAC_DIGITS)-1:0]       lap_time_o,
  output logic                                          lap_valid_o
);

  localparam int unsigned ND = MIN_DIGITS + 2 + FRAC_DIGITS;
  localparam int unsigned W  = 4 * ND;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   time_q,  time_d;
  logic           dir_q,   dir_d;     // 1 = counting down

  logic [W-1:0]   inc_val;
  logic [W-1:0]   dec_val;
  logic [W-1:0]   term_val;
  logic [W-1:0]   sat_val;
  logic           at_zero;
  logic           at_term;
  logic           load_acts;
  logic           count_done;

  // Largest legal value of digit position idx: seconds-tens stops at 5.
  function automatic logic [3:0] digit_max(input int unsigned idx);
    return (idx == FRAC_DIGITS + 1) ? 4'd5 : 4'd9;
  endfunction

  // Per-digit BCD arithmetic: increment with carry, decrement with borrow,
  // terminal (all-max) value and saturated preset.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    inc_val  = '0;
    dec_val  = '0;
    term_val = '0;
    sat_val  = '0;
    carry    = 1'b1;
    borrow   = 1'b1;
    d        = '0;
    for (int unsigned i = 0; i < ND; i++) begin
      d = time_q[4*i +: 4];
      if (carry) begin
        if (d >= digit_max(i)) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = d + 4'd1;
          carry             = 1'b0;
        end
      end else begin
        inc_val[4*i +: 4] = d;
      end

      if (borrow) begin
        if (d == 4'd0) begin
          dec_val[4*i +: 4] = digit_max(i);
        end else begin
          dec_val[4*i +: 4] = d - 4'd1;
          borrow            = 1'b0;
        end
      end else begin
        dec_val[4*i +: 4] = d;
      end

      term_val[4*i +: 4] = digit_max(i);

      d = load_val_i[4*i +: 4];
      sat_val[4*i +: 4] = (d > digit_max(i)) ? digit_max(i) : d;
    end
  end

  assign at_zero   = (time_q == '0);
  assign at_term   = (time_q == term_val);
  assign load_acts = load_i && (state_q != S_RUN);

  // Next-state and time update; clear > load > start, tick counts only in RUN.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    dir_d      = dir_q;
    count_done = 1'b0;

    if (clear_i) begin
      state_d = S_IDLE;
      time_d  = '0;
    end else if (load_acts) begin
      time_d  = sat_val;
      state_d = (sat_val == '0) ? S_IDLE : S_PAUSE;
    end else begin
      // A tick at the terminal value only expires; it never wraps.
      if ((state_q == S_RUN) && tick_i) begin
        if (dir_q) begin
          if (at_zero) begin
            count_done = 1'b1;
          end else begin
            time_d     = dec_val;
            count_done = (dec_val == '0);
          end
        end else begin
          if (at_term) begin
            count_done = 1'b1;
          end else begin
            time_d     = inc_val;
            count_done = (inc_val == term_val);
          end
        end
      end

      if (start_i) begin
        unique case (state_q)
          S_IDLE, S_PAUSE: begin
            state_d = S_RUN;
            dir_d   = mode_down_i;
          end
          S_RUN: begin
            state_d = count_done ? S_DONE : S_PAUSE;
          end
          S_DONE: begin
            dir_d   = mode_down_i;
            state_d = (mode_down_i ? at_zero : at_term) ? S_DONE : S_RUN;
          end
          default: state_d = S_IDLE;
        endcase
      end else if (count_done) begin
        state_d = S_DONE;
      end
    end
  end

  // State, time and direction registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      time_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      dir_q   <= dir_d;
    end
  end

  assign time_o    = time_q;
  assign running_o = (state_q == S_RUN);
  assign expired_o = (state_q == S_DONE);

`ifdef BCD_LAP_TIMER_LAP_CAPTURE_EN
  logic [W-1:0] lap_time_q, lap_time_d;
  logic         lap_valid_q, lap_valid_d;

  // Lap is lowest priority and snapshots the pre-tick time in RUN or PAUSE.
  always_comb begin
    lap_time_d  = lap_time_q;
    lap_valid_d = lap_valid_q;
    if (clear_i) begin
      lap_time_d  = '0;
      lap_valid_d = 1'b0;
    end else if (!load_acts && !start_i && lap_i &&
                 ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
      lap_time_d  = time_q;
      lap_valid_d = 1'b1;
    end
  end

  // Lap capture registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lap_time_q  <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_time_q  <= lap_time_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_time_o  = lap_time_q;
  assign lap_valid_o = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap  = lap_i;
  assign lap_time_o  = '0;
  assign lap_valid_o = 1'b0;
`endif

endmodule
